// File: rtl/aukv_pkg.sv
// Shared decode definitions for the aukv RV32I pipeline: opcodes, ALU operations,
// immediate formats and the ID/EX pipeline register layout.
package aukv_pkg;

  localparam int          XLEN      = 32;
  localparam int          ALU_OP_W  = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic            rd_we;
    alu_op_e         alu_op;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      mem_size;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            illegal;
  } idex_t;

  function automatic idex_t idex_bubble();
    idex_t e;
    e       = '0;
    e.instr = NOP_INSTR;
    return e;
  endfunction

  // alt selects SUB for funct3=0 and SRA for funct3=5
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/aukv_imm_gen.sv
// Immediate generator: classifies the instruction format from its opcode and
// produces the sign-extended RV32I immediate for it.
module aukv_imm_gen
  import aukv_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  always_comb begin
    fmt = FMT_I;
    case (instr[6:0])
      OPC_OP:             fmt = FMT_R;
      OPC_STORE:          fmt = FMT_S;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      default:            fmt = FMT_I;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/aukv_decode.sv
// RV32I decode stage: register-file read with writeback bypass, control decode,
// load-use hazard detection and the ID/EX pipeline register.
module aukv_decode
  import aukv_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [XLEN-1:0]     i_pc,
  input  logic [31:0]         i_instr,
  input  logic                i_instr_valid,
  input  logic                i_stall,
  input  logic                i_flush,
  output logic [4:0]          o_rs1_addr,
  output logic [4:0]          o_rs2_addr,
  input  logic [XLEN-1:0]     i_rs1_data,
  input  logic [XLEN-1:0]     i_rs2_data,
  input  logic                i_wb_we,
  input  logic [4:0]          i_wb_rd,
  input  logic [XLEN-1:0]     i_wb_data,
  output logic                o_hazard_stall,
  output logic                o_valid,
  output logic [XLEN-1:0]     o_pc,
  output logic [31:0]         o_instr,
  output logic [XLEN-1:0]     o_rs1_data,
  output logic [XLEN-1:0]     o_rs2_data,
  output logic [XLEN-1:0]     o_imm,
  output logic [4:0]          o_rd_addr,
  output logic                o_rd_we,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_src_a_pc,
  output logic                o_src_b_imm,
  output logic                o_mem_rd,
  output logic                o_mem_wr,
  output logic [2:0]          o_mem_size,
  output logic                o_branch,
  output logic                o_jal,
  output logic                o_jalr,
  output logic                o_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm;
  imm_fmt_e        fmt;
  logic            uses_rs1, uses_rs2, load_use;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  idex_t           idex_q, next_entry;

  logic            d_rd_we, d_src_a_pc, d_src_b_imm, d_mem_rd, d_mem_wr;
  logic            d_branch, d_jal, d_jalr, d_illegal;
  logic [2:0]      d_mem_size;
  alu_op_e         d_alu_op;

  assign opcode = i_instr[6:0];
  assign rd     = i_instr[11:7];
  assign f3     = i_instr[14:12];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];
  assign f7     = i_instr[31:25];

  assign o_rs1_addr = rs1;
  assign o_rs2_addr = rs2;

  aukv_imm_gen u_imm_gen (
    .instr (i_instr),
    .imm   (imm),
    .fmt   (fmt)
  );

  assign uses_rs1 = (fmt != FMT_U) && (fmt != FMT_J);
  assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

  always_comb begin
    d_rd_we     = 1'b0;
    d_alu_op    = ALU_ADD;
    d_src_a_pc  = 1'b0;
    d_src_b_imm = 1'b0;
    d_mem_rd    = 1'b0;
    d_mem_wr    = 1'b0;
    d_mem_size  = 3'd0;
    d_branch    = 1'b0;
    d_jal       = 1'b0;
    d_jalr      = 1'b0;
    d_illegal   = 1'b0;
    case (opcode)
      OPC_LUI:   begin d_rd_we = 1'b1; d_alu_op = ALU_PASS_B; d_src_b_imm = 1'b1; end
      OPC_AUIPC: begin d_rd_we = 1'b1; d_src_a_pc = 1'b1; d_src_b_imm = 1'b1; end
      OPC_JAL:   begin d_rd_we = 1'b1; d_jal = 1'b1; d_src_a_pc = 1'b1; d_src_b_imm = 1'b1; end
      OPC_JALR:  begin d_rd_we = 1'b1; d_jalr = 1'b1; d_src_b_imm = 1'b1; end
      OPC_BRANCH: begin
        d_branch = 1'b1;
        case (f3)
          3'd0, 3'd1: d_alu_op = ALU_SUB;
          3'd4, 3'd5: d_alu_op = ALU_SLT;
          3'd6, 3'd7: d_alu_op = ALU_SLTU;
          default:    d_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_rd_we     = 1'b1;
        d_mem_rd    = 1'b1;
        d_src_b_imm = 1'b1;
        d_mem_size  = f3;
        d_illegal   = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      OPC_STORE: begin
        d_mem_wr    = 1'b1;
        d_src_b_imm = 1'b1;
        d_mem_size  = f3;
        d_illegal   = (f3 >= 3'd3);
      end
      OPC_OP_IMM: begin
        d_rd_we     = 1'b1;
        d_src_b_imm = 1'b1;
        d_alu_op    = alu_from_funct(f3, (f3 == 3'd5) && f7[5]);
        d_illegal   = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                      ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      OPC_OP: begin
        d_rd_we   = 1'b1;
        d_alu_op  = alu_from_funct(f3, f7[5]);
        d_illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: d_illegal = 1'b1;
    endcase
    // An illegal instruction must not touch architectural state downstream
    if (d_illegal) begin
      d_rd_we     = 1'b0;
      d_alu_op    = ALU_ADD;
      d_src_a_pc  = 1'b0;
      d_src_b_imm = 1'b0;
      d_mem_rd    = 1'b0;
      d_mem_wr    = 1'b0;
      d_mem_size  = 3'd0;
      d_branch    = 1'b0;
      d_jal       = 1'b0;
      d_jalr      = 1'b0;
    end
    if (rd == 5'd0) d_rd_we = 1'b0;
  end

  assign rs1_fwd = (rs1 == 5'd0) ? '0 :
                   (i_wb_we && (i_wb_rd == rs1)) ? i_wb_data : i_rs1_data;
  assign rs2_fwd = (rs2 == 5'd0) ? '0 :
                   (i_wb_we && (i_wb_rd == rs2)) ? i_wb_data : i_rs2_data;

  assign load_use = idex_q.valid && idex_q.mem_rd && (idex_q.rd_addr != 5'd0) && i_instr_valid &&
                    ((uses_rs1 && (rs1 == idex_q.rd_addr)) || (uses_rs2 && (rs2 == idex_q.rd_addr)));
  assign o_hazard_stall = load_use && !i_stall && !i_flush;

  always_comb begin
    next_entry           = idex_bubble();
    next_entry.valid     = 1'b1;
    next_entry.pc        = i_pc;
    next_entry.instr     = i_instr;
    next_entry.rs1_data  = rs1_fwd;
    next_entry.rs2_data  = rs2_fwd;
    next_entry.imm       = imm;
    next_entry.rd_addr   = rd;
    next_entry.rd_we     = d_rd_we;
    next_entry.alu_op    = d_alu_op;
    next_entry.src_a_pc  = d_src_a_pc;
    next_entry.src_b_imm = d_src_b_imm;
    next_entry.mem_rd    = d_mem_rd;
    next_entry.mem_wr    = d_mem_wr;
    next_entry.mem_size  = d_mem_size;
    next_entry.branch    = d_branch;
    next_entry.jal       = d_jal;
    next_entry.jalr      = d_jalr;
    next_entry.illegal   = d_illegal;
  end

  // Flush beats stall; a load-use hit or an empty fetch slot inserts a bubble
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      idex_q <= idex_bubble();
    else if (i_flush || (!i_stall && (load_use || !i_instr_valid)))
      idex_q <= idex_bubble();
    else if (!i_stall)
      idex_q <= next_entry;
  end

  assign o_valid     = idex_q.valid;
  assign o_pc        = idex_q.pc;
  assign o_instr     = idex_q.instr;
  assign o_rs1_data  = idex_q.rs1_data;
  assign o_rs2_data  = idex_q.rs2_data;
  assign o_imm       = idex_q.imm;
  assign o_rd_addr   = idex_q.rd_addr;
  assign o_rd_we     = idex_q.rd_we;
  assign o_alu_op    = idex_q.alu_op;
  assign o_src_a_pc  = idex_q.src_a_pc;
  assign o_src_b_imm = idex_q.src_b_imm;
  assign o_mem_rd    = idex_q.mem_rd;
  assign o_mem_wr    = idex_q.mem_wr;
  assign o_mem_size  = idex_q.mem_size;
  assign o_branch    = idex_q.branch;
  assign o_jal       = idex_q.jal;
  assign o_jalr      = idex_q.jalr;
  assign o_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_aukv_decode.sv
// Self-checking bench for aukv_decode: directed cases followed by randomized
// traffic, all compared against a behavioural model of the decode stage.
module tb_aukv_decode;
  import aukv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [31:0] i_pc, i_instr, i_rs1_data, i_rs2_data, i_wb_data;
  logic        i_instr_valid, i_stall, i_flush, i_wb_we;
  logic [4:0]  i_wb_rd;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic        o_hazard_stall, o_valid, o_rd_we, o_src_a_pc, o_src_b_imm;
  logic        o_mem_rd, o_mem_wr, o_branch, o_jal, o_jalr, o_illegal;
  logic [31:0] o_pc, o_instr, o_rs1_data, o_rs2_data, o_imm;
  logic [3:0]  o_alu_op;
  logic [2:0]  o_mem_size;

  aukv_decode dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_pc(i_pc), .i_instr(i_instr),
    .i_instr_valid(i_instr_valid), .i_stall(i_stall), .i_flush(i_flush),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_hazard_stall(o_hazard_stall), .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
    .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we), .o_alu_op(o_alu_op),
    .o_src_a_pc(o_src_a_pc), .o_src_b_imm(o_src_b_imm), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .o_mem_size(o_mem_size), .o_branch(o_branch),
    .o_jal(o_jal), .o_jalr(o_jalr), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, instr, rs1d, rs2d, imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [3:0]  alu;
    logic        a_pc, b_imm, mrd, mwr;
    logic [2:0]  msz;
    logic        br, jal, jalr, ill;
    logic        known;
  } exp_t;

  localparam logic [3:0] ALU_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                         ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t m;
  logic last_hz;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sext(input int v, input int bits);
    int r;
    r = v;
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return 32'(r);
  endfunction

  // Reference decode written directly from the RV32I instruction rules
  function automatic void ref_decode(input logic [31:0] w, output exp_t e, output bit u1, output bit u2);
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit legal, writes;
    int imm_i, imm_s, imm_b, imm_j;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    imm_i = int'(w[31:20]);
    imm_s = int'(w[31:25]) * 32 + int'(w[11:7]);
    imm_b = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    imm_j = int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12) + int'(w[20]) * (1 << 11) + int'(w[30:21]) * 2;
    e = '0;
    e.valid = 1'b1; e.instr = w; e.rd = w[11:7]; e.alu = ALU_ADD; e.known = 1'b1;
    e.imm = sext(imm_i, 12);
    legal = 1; writes = 0; u1 = 1; u2 = 0;
    case (op)
      OPC_LUI:   begin writes = 1; e.alu = ALU_PASS_B; e.b_imm = 1; e.imm = w & 32'hFFFF_F000; u1 = 0; end
      OPC_AUIPC: begin writes = 1; e.a_pc = 1; e.b_imm = 1; e.imm = w & 32'hFFFF_F000; u1 = 0; end
      OPC_JAL:   begin writes = 1; e.jal = 1; e.a_pc = 1; e.b_imm = 1; e.imm = sext(imm_j, 21); u1 = 0; end
      OPC_JALR:  begin writes = 1; e.jalr = 1; e.b_imm = 1; end
      OPC_BRANCH: begin
        e.br = 1; e.imm = sext(imm_b, 13); u2 = 1;
        if (f3 inside {3'd0, 3'd1}) e.alu = ALU_SUB;
        else if (f3 inside {3'd4, 3'd5}) e.alu = ALU_SLT;
        else if (f3 inside {3'd6, 3'd7}) e.alu = ALU_SLTU;
        else legal = 0;
      end
      OPC_LOAD:  begin writes = 1; e.mrd = 1; e.b_imm = 1; e.msz = f3; legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
      OPC_STORE: begin e.mwr = 1; e.b_imm = 1; e.msz = f3; e.imm = sext(imm_s, 12); u2 = 1; legal = (f3 < 3); end
      OPC_OP_IMM: begin
        writes = 1; e.b_imm = 1;
        e.alu = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : ALU_TAB[f3];
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      OPC_OP: begin
        writes = 1; e.imm = 0; u2 = 1;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
        e.alu = (f7 == 7'h20 && f3 == 3'd0) ? ALU_SUB : (f7 == 7'h20 && f3 == 3'd5) ? ALU_SRA : ALU_TAB[f3];
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: legal = 0;
    endcase
    if (!legal) begin
      e.alu = ALU_ADD; e.a_pc = 0; e.b_imm = 0; e.mrd = 0; e.mwr = 0; e.msz = 0;
      e.br = 0; e.jal = 0; e.jalr = 0; e.ill = 1;
    end
    e.rd_we = writes && legal && (w[11:7] != 5'd0);
  endfunction

  function automatic exp_t bubble(input bit at_reset);
    exp_t e;
    e = '0;
    e.instr = NOP_INSTR;
    e.known = at_reset;
    return e;
  endfunction

  task automatic checkIdex(input string ctx);
    checkOutput({ctx, ".valid"},   o_valid,  m.valid);
    checkOutput({ctx, ".instr"},   o_instr,  m.instr);
    checkOutput({ctx, ".rd_we"},   o_rd_we,  m.rd_we);
    checkOutput({ctx, ".mem_rd"},  o_mem_rd, m.mrd);
    checkOutput({ctx, ".mem_wr"},  o_mem_wr, m.mwr);
    checkOutput({ctx, ".branch"},  o_branch, m.br);
    checkOutput({ctx, ".jal"},     o_jal,    m.jal);
    checkOutput({ctx, ".jalr"},    o_jalr,   m.jalr);
    checkOutput({ctx, ".illegal"}, o_illegal, m.ill);
    if (m.known) begin
      checkOutput({ctx, ".pc"},        o_pc,        m.pc);
      checkOutput({ctx, ".rs1_data"},  o_rs1_data,  m.rs1d);
      checkOutput({ctx, ".rs2_data"},  o_rs2_data,  m.rs2d);
      checkOutput({ctx, ".imm"},       o_imm,       m.imm);
      checkOutput({ctx, ".rd_addr"},   o_rd_addr,   m.rd);
      checkOutput({ctx, ".alu_op"},    o_alu_op,    m.alu);
      checkOutput({ctx, ".src_a_pc"},  o_src_a_pc,  m.a_pc);
      checkOutput({ctx, ".src_b_imm"}, o_src_b_imm, m.b_imm);
      checkOutput({ctx, ".mem_size"},  o_mem_size,  m.msz);
    end
  endtask

  // One fetch cycle: drive at negedge, check hazard combinationally, check ID/EX after the edge
  task automatic applyStimulus(input string ctx, input logic [31:0] instr, input logic valid,
                               input logic stall, input logic flush, input logic wb_we,
                               input logic [4:0] wb_rd, input logic [31:0] wb_data);
    exp_t d, n;
    bit u1, u2, hz;
    logic [4:0] a1, a2;
    @(negedge i_clk);
    i_instr = valid ? instr : NOP_INSTR;
    i_instr_valid = valid; i_pc = pc_ctr; i_stall = stall; i_flush = flush;
    i_wb_we = wb_we; i_wb_rd = wb_rd; i_wb_data = wb_data;
    i_rs1_data = $urandom; i_rs2_data = $urandom;
    ref_decode(i_instr, d, u1, u2);
    a1 = i_instr[19:15]; a2 = i_instr[24:20];
    hz = m.valid && m.mrd && (m.rd != 0) && valid && ((u1 && a1 == m.rd) || (u2 && a2 == m.rd)) && !stall && !flush;
    #1;
    checkOutput({ctx, ".hazard"},   o_hazard_stall, hz);
    checkOutput({ctx, ".rs1_addr"}, o_rs1_addr, a1);
    checkOutput({ctx, ".rs2_addr"}, o_rs2_addr, a2);
    last_hz = o_hazard_stall;
    d.pc   = pc_ctr;
    d.rs1d = (a1 == 0) ? 0 : (wb_we && wb_rd == a1) ? wb_data : i_rs1_data;
    d.rs2d = (a2 == 0) ? 0 : (wb_we && wb_rd == a2) ? wb_data : i_rs2_data;
    if (flush)       n = bubble(0);
    else if (stall)  n = m;
    else if (hz)     n = bubble(0);
    else if (!valid) n = bubble(0);
    else             n = d;
    @(posedge i_clk);
    #1;
    m = n;
    checkIdex(ctx);
  endtask

  task automatic plain(input string ctx, input logic [31:0] instr);
    applyStimulus(ctx, instr, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    pc_ctr += 4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm12;
    logic [6:0]  f7;
    rd = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom); imm12 = 12'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 11))
      0:  return {20'($urandom), rd, OPC_LUI};
      1:  return {20'($urandom), rd, OPC_AUIPC};
      2:  return {20'($urandom), rd, OPC_JAL};
      3:  return {imm12, rs1, 3'd0, rd, OPC_JALR};
      4:  return {7'($urandom), rs2, rs1, f3, 5'($urandom), OPC_BRANCH};
      5:  return {imm12, rs1, f3, rd, OPC_LOAD};
      6:  return {7'($urandom), rs2, rs1, f3, 5'($urandom), OPC_STORE};
      7:  return $urandom_range(0, 1) ? {f7, 5'($urandom), rs1, f3, rd, OPC_OP_IMM}
                                      : {imm12, rs1, f3, rd, OPC_OP_IMM};
      8:  return {f7, rs2, rs1, f3, rd, OPC_OP};
      9:  return {imm12, rs1, f3, rd, $urandom_range(0, 1) ? OPC_MISC_MEM : OPC_SYSTEM};
      10: return $urandom;
      default: return {imm12, rs1, 3'd2, rd, OPC_LOAD};
    endcase
  endfunction

  initial begin
    logic [31:0] ins;
    i_rstn = 1'b0; i_pc = 0; i_instr = NOP_INSTR; i_instr_valid = 0; i_stall = 0; i_flush = 0;
    i_rs1_data = 0; i_rs2_data = 0; i_wb_we = 0; i_wb_rd = 0; i_wb_data = 0; last_hz = 0;
    m = bubble(1);
    repeat (2) @(posedge i_clk);
    #1;
    checkIdex("reset");
    checkOutput("reset.hazard", o_hazard_stall, 1'b0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    plain("addi", 32'h0050_0093);
    checkOutput("addi.imm5", o_imm, 32'd5);
    checkOutput("addi.rd1", o_rd_addr, 5'd1);
    checkOutput("addi.we", o_rd_we, 1'b1);
    checkOutput("addi.bimm", o_src_b_imm, 1'b1);
    checkOutput("addi.alu", o_alu_op, ALU_ADD);

    plain("lw", 32'h0000_A103);
    applyStimulus("lu_add", 32'h0021_01B3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("lu.stall_req", last_hz, 1'b1);
    checkOutput("lu.bubble", o_valid, 1'b0);
    plain("lu_issue", 32'h0021_01B3);
    checkOutput("lu.no_stall", last_hz, 1'b0);
    checkOutput("lu.add_valid", o_valid, 1'b1);
    checkOutput("lu.add_instr", o_instr, 32'h0021_01B3);

    applyStimulus("bypass", 32'h0002_02B3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_DEAD);
    pc_ctr += 4;
    checkOutput("bypass.rs1", o_rs1_data, 32'h0000_DEAD);
    checkOutput("bypass.x0", o_rs2_data, 32'h0);

    plain("pre_stall", 32'h0050_0093);
    applyStimulus("stall1", 32'h0021_01B3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus("stall2", 32'h0000_A103, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus("stall3", 32'hFE00_0EE3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("stall.frozen", o_instr, 32'h0050_0093);
    applyStimulus("flush_in_stall", 32'h0021_01B3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("flush.valid", o_valid, 1'b0);
    checkOutput("flush.nop", o_instr, NOP_INSTR);

    plain("ill", 32'hFFFF_FFFF);
    checkOutput("ill.flag", o_illegal, 1'b1);
    checkOutput("ill.we", o_rd_we, 1'b0);
    checkOutput("ill.mwr", o_mem_wr, 1'b0);
    plain("addi_x0", 32'h0010_0013);
    checkOutput("x0.we", o_rd_we, 1'b0);
    plain("beq", 32'hFE00_0EE3);
    checkOutput("beq.branch", o_branch, 1'b1);
    checkOutput("beq.imm", o_imm, 32'hFFFF_FFFC);
    plain("fence", 32'h0FF0_000F);
    checkOutput("fence.valid", o_valid, 1'b1);

    ins = rand_instr();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!last_hz) begin
        ins = rand_instr();
        pc_ctr += 4;
      end
      applyStimulus("rand", ins, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 5, 1'($urandom), 5'($urandom_range(0, 4)), $urandom);
      if (cyc == 700) begin
        @(negedge i_clk);
        #2 i_rstn = 1'b0;
        #1;
        m = bubble(1);
        checkIdex("async_rst");
        @(posedge i_clk);
        #1;
        checkIdex("async_rst_hold");
        @(negedge i_clk);
        i_rstn = 1'b1;
        last_hz = 0;
      end
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
